mac_seq_ctrl: RTL and testbench



---
 rtl/mac_seq_ctrl.sv | 131 +++++++++++++
 tb/tb_mac_seq_ctrl.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/mac_seq_ctrl.sv
// Sequencer for the MAC array west-edge instruction bus and L0 read strobe.
// WS mode: kernel load, kernel flush, execute, drain. OS mode: execute, drain.
module mac_seq_ctrl #(
  parameter int row    = 8,
  parameter int col    = 8,
  parameter int len_bw = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              mode_in,
  input  logic [len_bw-1:0] len,
  input  logic              l0_empty,
  input  logic              ofifo_full,
  output logic              l0_rd,
  output logic [1:0]        inst_w,
  output logic              mode,
  output logic              busy,
  output logic              done,
  output logic [len_bw-1:0] issue_cnt
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] KLOAD  = 3'd1;
  localparam logic [2:0] KFLUSH = 3'd2;
  localparam logic [2:0] EXEC   = 3'd3;
  localparam logic [2:0] DRAIN  = 3'd4;
  localparam logic [2:0] DONE   = 3'd5;

  // Phase counter covers both the flush (col) and drain (row+col) windows.
  localparam int PH_W = $clog2(row + col + 1);

  logic [2:0]        state, state_nxt;
  logic [len_bw-1:0] len_q;
  logic [len_bw-1:0] cnt_nxt;
  logic [PH_W-1:0]   ph_cnt, ph_nxt;
  logic              kload_fire, exec_fire;

  assign kload_fire = (state == KLOAD) && !l0_empty;
  assign exec_fire  = (state == EXEC) && !l0_empty && !ofifo_full;
  assign l0_rd      = kload_fire | exec_fire;
  assign busy       = (state != IDLE);
  assign done       = (state == DONE);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = issue_cnt;
    ph_nxt    = ph_cnt;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        ph_nxt  = '0;
        if (start) begin
          if (len == '0)
            state_nxt = DONE;
          else if (mode_in)
            state_nxt = EXEC;
          else
            state_nxt = KLOAD;
        end
      end
      KLOAD: begin
        if (kload_fire) begin
          if (issue_cnt == len_bw'(row - 1)) begin
            state_nxt = KFLUSH;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = issue_cnt + len_bw'(1);
          end
        end
      end
      KFLUSH: begin
        if (ph_cnt == PH_W'(col - 1)) begin
          state_nxt = EXEC;
          ph_nxt    = '0;
        end else begin
          ph_nxt = ph_cnt + PH_W'(1);
        end
      end
      EXEC: begin
        // len_q is nonzero here: a zero length bypasses EXEC from IDLE.
        if (exec_fire) begin
          if (issue_cnt == len_q - len_bw'(1)) begin
            state_nxt = DRAIN;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = issue_cnt + len_bw'(1);
          end
        end
      end
      DRAIN: begin
        if (ph_cnt == PH_W'(row + col - 1)) begin
          state_nxt = DONE;
          ph_nxt    = '0;
        end else begin
          ph_nxt = ph_cnt + PH_W'(1);
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
        ph_nxt    = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      issue_cnt <= '0;
      ph_cnt    <= '0;
      inst_w    <= '0;
      mode      <= 1'b0;
      len_q     <= '0;
    end else begin
      state     <= state_nxt;
      issue_cnt <= cnt_nxt;
      ph_cnt    <= ph_nxt;
      // Registered so the instruction lines up with the registered L0 data.
      inst_w    <= {exec_fire, kload_fire};
      if ((state == IDLE) && start) begin
        mode  <= mode_in;
        len_q <= len;
      end
    end
  end

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Randomized bench for mac_seq_ctrl: a per-operation schedule is derived from
// the phase rules and the stall pattern, then compared cycle by cycle.
module tb_mac_seq_ctrl;

  localparam int ROW  = 8;
  localparam int COL  = 8;
  localparam int LBW  = 8;
  localparam int MAXC = 2048;

  logic           clk = 1'b0;
  logic           reset, start, mode_in, l0_empty, ofifo_full;
  logic [LBW-1:0] len;
  logic           l0_rd, mode, busy, done;
  logic [1:0]     inst_w;
  logic [LBW-1:0] issue_cnt;

  mac_seq_ctrl #(.row(ROW), .col(COL), .len_bw(LBW)) dut (
    .clk(clk), .reset(reset), .start(start), .mode_in(mode_in), .len(len),
    .l0_empty(l0_empty), .ofifo_full(ofifo_full), .l0_rd(l0_rd),
    .inst_w(inst_w), .mode(mode), .busy(busy), .done(done),
    .issue_cnt(issue_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // stimulus per cycle of an operation (cycle 0 is the start cycle)
  bit           emp_a [MAXC];
  bit           ful_a [MAXC];
  bit           st_a  [MAXC];
  bit           smd_a [MAXC];
  bit [LBW-1:0] sln_a [MAXC];
  // expected outputs per cycle
  bit           e_rd   [MAXC];
  bit [1:0]     e_inst [MAXC];
  bit           e_busy [MAXC];
  int           e_cnt  [MAXC];
  int           done_t;
  bit           cur_mode = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Walk the phases: fires consume stimulus cycles, fixed windows consume time.
  task automatic build(input bit m, input int unsigned n);
    int t, k;
    for (int i = 0; i < MAXC; i++) begin
      e_rd[i] = 0; e_inst[i] = 2'b00; e_busy[i] = 0; e_cnt[i] = 0;
    end
    t = 1;
    if (n != 0) begin
      if (!m) begin
        k = 0;
        while (k < ROW && t < MAXC - 4) begin
          e_busy[t] = 1; e_cnt[t] = k;
          if (!emp_a[t]) begin e_rd[t] = 1; e_inst[t+1] = 2'b01; k++; end
          t++;
        end
        for (int i = 0; i < COL; i++) begin e_busy[t] = 1; t++; end
      end
      k = 0;
      while (k < int'(n) && t < MAXC - 4) begin
        e_busy[t] = 1; e_cnt[t] = k;
        if (!emp_a[t] && !ful_a[t]) begin e_rd[t] = 1; e_inst[t+1] = 2'b10; k++; end
        t++;
      end
      for (int i = 0; i < ROW + COL; i++) begin e_busy[t] = 1; t++; end
    end
    done_t = t;
    e_busy[t] = 1;
  endtask

  // stall_pct < 0 keeps a stall pattern preloaded by the caller.
  // rst_sel: -1 no reset, -2 random cycle inside the operation, else that cycle.
  task automatic run_op(input bit m, input int unsigned n, input int stall_pct,
                        input bit extra_starts, input int rst_sel);
    int rst_at, last, ndone, dut_done_t;
    bit exp_mode, in_rst;
    if (stall_pct >= 0)
      for (int i = 0; i < MAXC; i++) begin
        emp_a[i] = (i < 1000) && ($urandom_range(99) < stall_pct);
        ful_a[i] = (i < 1000) && ($urandom_range(99) < stall_pct);
      end
    build(m, n);
    for (int i = 0; i < MAXC; i++) begin
      st_a[i] = 0; smd_a[i] = 1'($urandom); sln_a[i] = LBW'($urandom);
    end
    st_a[0] = 1; smd_a[0] = m; sln_a[0] = LBW'(n);
    if (extra_starts) begin
      for (int i = 1; i <= done_t; i++) st_a[i] = ($urandom_range(3) == 0);
      st_a[done_t] = 1;
    end
    rst_at = rst_sel;
    if (rst_sel == -2) rst_at = int'($urandom_range(done_t, 1));
    last  = (rst_at >= 0) ? rst_at + 1 : done_t + 1;
    ndone = 0;
    dut_done_t = -1;
    for (int t = 0; t <= last; t++) begin
      @(posedge clk); #1;
      start      = st_a[t];
      mode_in    = smd_a[t];
      len        = sln_a[t];
      l0_empty   = emp_a[t];
      ofifo_full = ful_a[t];
      reset      = (t == rst_at);
      @(negedge clk);
      in_rst   = (rst_at >= 0) && (t == rst_at + 1);
      exp_mode = (t == 0) ? cur_mode : m;
      if (in_rst) begin
        check("rst_l0_rd", l0_rd, 0);
        check("rst_inst_w", inst_w, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_issue_cnt", issue_cnt, 0);
        check("rst_mode", mode, 0);
      end else begin
        check("l0_rd", l0_rd, e_rd[t]);
        check("inst_w", inst_w, e_inst[t]);
        check("busy", busy, e_busy[t]);
        check("done", done, (t == done_t));
        check("issue_cnt", issue_cnt, e_cnt[t]);
        check("mode", mode, exp_mode);
      end
      if (done === 1'b1) begin ndone++; dut_done_t = t; end
    end
    reset = 0;
    start = 0;
    if (rst_at >= 0) begin
      check("done_pulses_rst", ndone, (rst_at >= done_t) ? 1 : 0);
      cur_mode = 1'b0;
    end else begin
      check("done_pulses", ndone, 1);
      check("done_cycle", dut_done_t, done_t);
      cur_mode = m;
    end
  endtask

  initial begin
    reset = 1; start = 0; mode_in = 0; len = '0; l0_empty = 1; ofifo_full = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_inst_w", inst_w, 0);
    check("reset_issue_cnt", issue_cnt, 0);
    check("reset_mode", mode, 0);
    check("reset_l0_rd", l0_rd, 0);
    @(posedge clk); #1 reset = 0;

    // WS nominal and OS nominal
    run_op(0, 4, 0, 0, -1);
    run_op(1, 3, 0, 0, -1);
    // WS with two empty cycles in KLOAD and three full cycles in EXEC
    for (int i = 0; i < MAXC; i++) begin emp_a[i] = 0; ful_a[i] = 0; end
    emp_a[3] = 1; emp_a[4] = 1;
    ful_a[20] = 1; ful_a[21] = 1; ful_a[22] = 1;
    run_op(0, 4, -1, 0, -1);
    // simultaneous empty/full and single-sided release in EXEC (OS)
    for (int i = 0; i < MAXC; i++) begin emp_a[i] = 0; ful_a[i] = 0; end
    emp_a[2] = 1; ful_a[2] = 1; emp_a[3] = 1; ful_a[4] = 1;
    run_op(1, 3, -1, 0, -1);
    // zero length
    run_op(0, 0, 0, 0, -1);
    run_op(1, 0, 0, 0, -1);
    // reset during EXEC after two fires, then a clean OS len=1
    run_op(1, 6, 0, 0, 3);
    run_op(1, 1, 0, 0, -1);
    // starts during busy cycles and on the DONE cycle are ignored
    run_op(0, 5, 20, 1, -1);
    // maximum length
    run_op(1, 255, 0, 0, -1);
    run_op(0, 255, 15, 1, -1);
    // random operations
    for (int r = 0; r < 16; r++)
      run_op(1'($urandom), $urandom_range(20), int'($urandom_range(40)),
             1'($urandom), ($urandom_range(4) == 0) ? -2 : -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
